// File: rtl/mc_main_control.sv
// Main control FSM for the multi-cycle MIPS core.
// Drives datapath selects and write strobes for each state.
module mc_main_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       ext_op,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_e state_q, state_d;
  logic   r_ok;

  always_ff @(posedge clk) begin
    if (rst) state_q <= state_e'(RESET_STATE);
    else     state_q <= state_d;
  end

  assign state_dbg = state_q;

  always_comb begin
    r_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
           (funct == FN_AND) || (funct == FN_OR)  ||
           (funct == FN_SLT);
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'b010;
    pc_src     = 2'b00;
    ext_op     = 1'b1;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):       state_d = S_MEM_ADDR;
          (opcode == OP_R) && r_ok: state_d = S_R_EXEC;
          (opcode == OP_BEQ):      state_d = S_BRANCH;
          (opcode == OP_J):        state_d = S_JUMP;
          (opcode == OP_ADDI),
          (opcode == OP_ANDI),
          (opcode == OP_ORI):      state_d = S_I_EXEC;
          default:                 state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE
                                      : S_MEM_READ;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        unique case (funct)
          FN_SUB:  alu_ctrl = 3'b110;
          FN_AND:  alu_ctrl = 3'b000;
          FN_OR:   alu_ctrl = 3'b001;
          FN_SLT:  alu_ctrl = 3'b111;
          default: alu_ctrl = 3'b010;
        endcase
        state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b110;
        pc_src    = 2'b01;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (opcode)
          OP_ANDI: begin
            alu_ctrl = 3'b000;
            ext_op   = 1'b0;
          end
          OP_ORI: begin
            alu_ctrl = 3'b001;
            ext_op   = 1'b0;
          end
          default: alu_ctrl = 3'b010;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_FETCH;
    endcase

    // Reset aborts any access in flight, so gate everything here.
    if (rst) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b010;
      pc_src     = 2'b00;
      ext_op     = 1'b1;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: table-driven instruction flows
// plus hand-built wait, reset and illegal sequences.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic       ext_op, illegal;
  logic [3:0] state_dbg;

  mc_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_src(pc_src), .ext_op(ext_op),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       ext;
    logic       illegal;
  } exp_t;

  typedef struct {
    exp_t e;
    int   tag;
  } sb_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         n;
    logic [3:0] seq [5];
    logic [2:0] alu;
    logic       ext;
  } vec_t;

  sb_t  sb [$];
  int   checks = 0;
  int   passes = 0;
  int   tag    = 0;
  vec_t vecs [13];

  function automatic exp_t rst_row(input logic [3:0] s);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.alu = 3'b010;
    e.ext = 1'b1;
    return e;
  endfunction

  // Expected outputs for one cycle, straight from the state table.
  function automatic exp_t exp_row(
    input logic [3:0] s, input logic mr, input logic z,
    input logic [2:0] fa, input logic fe);
    exp_t e;
    e = rst_row(s);
    case (s)
      4'd0: begin
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = mr;
        e.pc_en     = mr;
      end
      4'd1: e.alu_src_b = 2'b11;
      4'd2: begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
      end
      4'd3: begin
        e.iord     = 1'b1;
        e.mem_read = 1'b1;
      end
      4'd4: begin
        e.reg_write  = 1'b1;
        e.mem_to_reg = 1'b1;
      end
      4'd5: begin
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
      end
      4'd6: begin
        e.alu_src_a = 1'b1;
        e.alu       = fa;
      end
      4'd7: begin
        e.reg_write = 1'b1;
        e.reg_dst   = 1'b1;
      end
      4'd8: begin
        e.alu_src_a = 1'b1;
        e.alu       = 3'b110;
        e.pc_src    = 2'b01;
        e.pc_en     = z;
      end
      4'd9: begin
        e.pc_src = 2'b10;
        e.pc_en  = 1'b1;
      end
      4'd10: begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        e.alu       = fa;
        e.ext       = fe;
      end
      4'd11: e.reg_write = 1'b1;
      4'd12: e.illegal = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic vec_t mkv(
    input logic [5:0] op, input logic [5:0] fn,
    input logic z, input int n,
    input logic [3:0] s0, input logic [3:0] s1,
    input logic [3:0] s2, input logic [3:0] s3,
    input logic [3:0] s4,
    input logic [2:0] alu, input logic ext);
    vec_t v;
    v.op     = op;
    v.fn     = fn;
    v.z      = z;
    v.n      = n;
    v.seq[0] = s0;
    v.seq[1] = s1;
    v.seq[2] = s2;
    v.seq[3] = s3;
    v.seq[4] = s4;
    v.alu    = alu;
    v.ext    = ext;
    return v;
  endfunction

  always @(negedge clk) begin
    sb_t  x;
    exp_t a;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      a = {state_dbg, pc_en, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, pc_src,
           ext_op, illegal};
      checks++;
      if (a !== x.e)
        $display("FAIL cyc%0d: got %h expected %h",
                 x.tag, a, x.e);
      else
        passes++;
    end
  end

  task automatic cyc(input logic r, input logic mr,
                     input exp_t e);
    rst       = r;
    mem_ready = mr;
    sb.push_back('{e: e, tag: tag});
    tag++;
    @(posedge clk);
    #1;
  endtask

  task automatic nrm(input logic [3:0] s, input logic mr);
    cyc(1'b0, mr, exp_row(s, mr, zero, 3'b010, 1'b1));
  endtask

  initial begin
    vecs[0]  = mkv(6'h00, 6'h20, 0, 4, 0, 1, 6, 7, 0,
                   3'b010, 1);
    vecs[1]  = mkv(6'h00, 6'h22, 0, 4, 0, 1, 6, 7, 0,
                   3'b110, 1);
    vecs[2]  = mkv(6'h00, 6'h24, 0, 4, 0, 1, 6, 7, 0,
                   3'b000, 1);
    vecs[3]  = mkv(6'h00, 6'h25, 0, 4, 0, 1, 6, 7, 0,
                   3'b001, 1);
    vecs[4]  = mkv(6'h00, 6'h2A, 0, 4, 0, 1, 6, 7, 0,
                   3'b111, 1);
    vecs[5]  = mkv(6'h23, 6'h15, 0, 5, 0, 1, 2, 3, 4,
                   3'b010, 1);
    vecs[6]  = mkv(6'h2B, 6'h00, 1, 4, 0, 1, 2, 5, 0,
                   3'b010, 1);
    vecs[7]  = mkv(6'h04, 6'h00, 1, 3, 0, 1, 8, 0, 0,
                   3'b010, 1);
    vecs[8]  = mkv(6'h04, 6'h00, 0, 3, 0, 1, 8, 0, 0,
                   3'b010, 1);
    vecs[9]  = mkv(6'h02, 6'h3F, 0, 3, 0, 1, 9, 0, 0,
                   3'b010, 1);
    vecs[10] = mkv(6'h0D, 6'h00, 0, 4, 0, 1, 10, 11, 0,
                   3'b001, 0);
    vecs[11] = mkv(6'h08, 6'h00, 0, 4, 0, 1, 10, 11, 0,
                   3'b010, 1);
    vecs[12] = mkv(6'h0C, 6'h2A, 0, 4, 0, 1, 10, 11, 0,
                   3'b000, 0);

    rst       = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, rst_row(4'd0));

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      zero   = vecs[i].z;
      for (int k = 0; k < vecs[i].n; k++)
        cyc(1'b0, 1'b1,
            exp_row(vecs[i].seq[k], 1'b1, vecs[i].z,
                    vecs[i].alu, vecs[i].ext));
    end

    // lw with two fetch waits and three read waits: 10 cycles
    opcode = 6'h23;
    zero   = 1'b1;
    nrm(4'd0, 1'b0);
    nrm(4'd0, 1'b0);
    nrm(4'd0, 1'b1);
    nrm(4'd1, 1'b0);
    nrm(4'd2, 1'b0);
    nrm(4'd3, 1'b0);
    nrm(4'd3, 1'b0);
    nrm(4'd3, 1'b0);
    nrm(4'd3, 1'b1);
    nrm(4'd4, 1'b0);

    // sw stalled in MEM_WRITE, then reset for two cycles
    opcode = 6'h2B;
    nrm(4'd0, 1'b1);
    nrm(4'd1, 1'b1);
    nrm(4'd2, 1'b1);
    nrm(4'd5, 1'b0);
    nrm(4'd5, 1'b0);
    cyc(1'b1, 1'b1, rst_row(4'd5));
    cyc(1'b1, 1'b1, rst_row(4'd0));
    opcode = 6'h00;
    funct  = 6'h20;
    nrm(4'd0, 1'b1);
    nrm(4'd1, 1'b1);
    cyc(1'b0, 1'b1, exp_row(4'd6, 1, 0, 3'b010, 1));
    nrm(4'd7, 1'b1);

    // illegal opcode, then R-type with unsupported funct
    for (int t = 0; t < 2; t++) begin
      opcode = (t == 0) ? 6'h3F : 6'h00;
      funct  = (t == 0) ? 6'h20 : 6'h03;
      nrm(4'd0, 1'b1);
      nrm(4'd1, 1'b1);
      for (int k = 0; k < 5; k++) begin
        opcode = 6'($urandom_range(0, 63));
        zero   = k[0];
        nrm(4'd12, k[1]);
      end
      cyc(1'b1, 1'b1, rst_row(4'd12));
      nrm(4'd0, 1'b0);
    end

    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d left, expected 0",
               sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
